// File: rtl/imm_field_decode_pkg.sv
// Shared definitions for the immediate-field decoder: instruction field map,
// widths, skid-buffer state encoding and the decoded field record.
package imm_field_decode_pkg;

   localparam int IW         = 32;
   localparam int IMMW       = 17;
   localparam int CNTW_DFLT  = 16;

   // Instruction field bit positions
   localparam int OPC_HI     = 31;
   localparam int OPC_LO     = 26;
   localparam int RS_HI      = 25;
   localparam int RS_LO      = 21;
   localparam int RT_HI      = 20;
   localparam int RT_LO      = 16;
   localparam int I27_BIT    = 27;
   localparam int OFS_HI     = 15;  // top bit of the 16-bit load/store offset
   localparam int ITYPE_HI   = IMMW - 1;

   // Buffer occupancy: output slot only, or output slot plus skid slot
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   // One decoded instruction as stored in either buffer slot
   typedef struct packed {
      logic [OPC_HI-OPC_LO:0] opcode;
      logic [RS_HI-RS_LO:0]   rs;
      logic [RT_HI-RT_LO:0]   rt;
      logic                   i27;
      logic [IMMW-1:0]        mem_type;
      logic [IMMW-1:0]        i_type;
   } fields_t;

endpackage

// File: rtl/imm_field_decode_extract.sv
// Pure combinational slicing of a raw instruction into the decoded field record.
module imm_field_extract
   import imm_field_decode_pkg::*;
(
   input  logic [IW-1:0] instr,
   output fields_t       fields
);

   assign fields.opcode   = instr[OPC_HI:OPC_LO];
   assign fields.rs       = instr[RS_HI:RS_LO];
   assign fields.rt       = instr[RT_HI:RT_LO];
   assign fields.i27      = instr[I27_BIT];
   // Load/store offset: 16-bit value sign-extended by one bit
   assign fields.mem_type = {instr[OFS_HI], instr[OFS_HI:0]};
   assign fields.i_type   = instr[ITYPE_HI:0];

endmodule

// File: rtl/imm_field_decode.sv
// Decode stage feeding the immediate select mux: extracts instruction fields
// and holds them in a two-entry skid buffer with registered valid/ready.
module imm_field_decode
   import imm_field_decode_pkg::*;
#(
   parameter int CNTW = CNTW_DFLT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IW-1:0]   instr_in,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      opcode,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic            I27,
   output logic [IMMW-1:0] mem_type,
   output logic [IMMW-1:0] I_type,
   output logic [CNTW-1:0] decode_cnt
);

   state_e          state_q, state_d;
   fields_t         new_fields;
   fields_t         out_q, skid_q;
   logic            in_ready_q;
   logic [CNTW-1:0] cnt_q;
   logic            in_xfer, out_xfer;
   logic            load_out, load_skid, skid_to_out;

   imm_field_extract u_extract (
      .instr  (instr_in),
      .fields (new_fields)
   );

   assign out_valid = (state_q != ST_EMPTY);
   assign in_xfer   = in_valid  & in_ready_q;
   assign out_xfer  = out_valid & out_ready;

   // Next-state and slot-load decisions; flush overrides everything
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
      state_d     = state_q;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  state_d  = ST_ONE;
                  load_out = 1'b1;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  load_out = 1'b1;
               end else if (in_xfer) begin
                  state_d   = ST_TWO;
                  load_skid = 1'b1;
               end else if (out_xfer) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_xfer) begin
                  state_d     = ST_ONE;
                  skid_to_out = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // State, registered ready and completed-handshake counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_TWO);
         if (out_xfer) cnt_q <= cnt_q + 1'b1;
      end
   end

   // Output and skid field records; output holds steady unless reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data slots are reset because the field outputs must read zero out of reset.
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out)         out_q <= new_fields;
         else if (skid_to_out) out_q <= skid_q;
         if (load_skid)        skid_q <= new_fields;
      end
   end

   assign in_ready   = in_ready_q;
   assign decode_cnt = cnt_q;
   assign opcode     = out_q.opcode;
   assign rs         = out_q.rs;
   assign rt         = out_q.rt;
   assign I27        = out_q.i27;
   assign mem_type   = out_q.mem_type;
   assign I_type     = out_q.i_type;

endmodule

// File: tb/tb_imm_field_decode.sv
// Scoreboard bench for imm_field_decode: a queue model of the buffered
// instructions is updated on every handshake and compared at each falling edge.
module tb_imm_field_decode;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr_in = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  opcode;
   logic [4:0]  rs, rt;
   logic        I27;
   logic [16:0] mem_type, I_type;
   logic [15:0] decode_cnt;

   imm_field_decode dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instr_in   (instr_in),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .opcode     (opcode),
      .rs         (rs),
      .rt         (rt),
      .I27        (I27),
      .mem_type   (mem_type),
      .I_type     (I_type),
      .decode_cnt (decode_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  opc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        i27;
      logic [16:0] mt;
      logic [16:0] it;
   } exp_t;

   exp_t        q[$];
   logic [15:0] exp_cnt = '0;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode from the field definitions using plain arithmetic
   function automatic exp_t ref_decode(input logic [31:0] x);
      exp_t        e;
      logic [31:0] lo;
      e.opc = 6'(x >> 26);
      e.rs  = 5'(x >> 21);
      e.rt  = 5'(x >> 16);
      e.i27 = 1'(x >> 27);
      lo    = x & 32'h0000_FFFF;
      e.mt  = (lo >= 32'h8000) ? 17'(lo + 32'h0001_0000) : 17'(lo);
      e.it  = 17'(x);
      return e;
   endfunction

   // Monitor: compare against the queue model, then apply this cycle's handshakes
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         exp_cnt = '0;
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_in_ready", 32'(in_ready), 32'd1);
         check("rst_cnt", 32'(decode_cnt), 32'd0);
         check("rst_fields", {opcode, rs, rt, I27, 15'd0}, 32'd0);
         check("rst_imm", {mem_type[14:0], I_type}, 32'd0);
      end else begin
         check("out_valid", 32'(out_valid), 32'(q.size() != 0));
         check("in_ready", 32'(in_ready), 32'(q.size() < 2));
         check("decode_cnt", 32'(decode_cnt), 32'(exp_cnt));
         if (out_valid && q.size() > 0) begin
            check("opcode", 32'(opcode), 32'(q[0].opc));
            check("rs", 32'(rs), 32'(q[0].rs));
            check("rt", 32'(rt), 32'(q[0].rt));
            check("I27", 32'(I27), 32'(q[0].i27));
            check("mem_type", 32'(mem_type), 32'(q[0].mt));
            check("I_type", 32'(I_type), 32'(q[0].it));
         end
         if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
         end
         if (flush) q.delete();
         else if (in_valid && in_ready) q.push_back(ref_decode(instr_in));
      end
   end

   // Present one instruction until accepted, bounded
   task automatic send(input logic [31:0] x);
      bit ok, now;
      ok = 1'b0;
      in_valid = 1'b1;
      instr_in = x;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         now = in_ready;
         @(posedge clk);
         #1;
         ok = now;
      end
      in_valid = 1'b0;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 50 && !idle; i++) begin
         @(posedge clk);
         #1;
         idle = !out_valid;
      end
      if (!idle) check("drain_timeout", 32'd0, 32'd1);
   endtask

   exp_t        e;
   logic [15:0] cnt0;
   int          c0;
   int          n;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Field decode of the reference instruction
      out_ready = 1'b1;
      send(32'h0823_8004);
      check("dec_opcode", 32'(opcode), 32'h02);
      check("dec_rs", 32'(rs), 32'h01);
      check("dec_rt", 32'(rt), 32'h03);
      check("dec_I27", 32'(I27), 32'h1);
      check("dec_mem_type", 32'(mem_type), 32'h1_8004);
      check("dec_I_type", 32'(I_type), 32'h1_8004);

      // Positive offset with bit 16 set: the two immediates differ
      send(32'h0001_7FFF);
      check("sign_mem_type", 32'(mem_type), 32'h0_7FFF);
      check("sign_I_type", 32'(I_type), 32'h1_7FFF);
      wait_idle();

      // Backpressure: two accepted, third held off while outputs stay put
      out_ready = 1'b0;
      cnt0 = decode_cnt;
      send(32'hA5A5_1234);
      send(32'h5A5A_8765);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      e = ref_decode(32'hA5A5_1234);
      in_valid = 1'b1;
      instr_in = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_hold_mem_type", 32'(mem_type), 32'(e.mt));
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      send(32'hDEAD_BEEF);
      send(32'h1357_9BDF);
      wait_idle();
      check("bp_count", 32'(decode_cnt - cnt0), 32'd4);

      // Throughput: 100 back-to-back instructions, one per clock
      cnt0 = decode_cnt;
      c0 = cyc;
      for (int i = 0; i < 100; i++) send($urandom);
      @(posedge clk); #1;
      check("tp_cycles", 32'(cyc - c0), 32'd101);
      check("tp_count", 32'(decode_cnt - cnt0), 32'd100);
      check("tp_idle", 32'(out_valid), 32'd0);

      // Flush while full with a competing input
      out_ready = 1'b0;
      send(32'h1111_1111);
      send(32'h2222_2222);
      cnt0 = decode_cnt;
      in_valid = 1'b1;
      instr_in = 32'h3333_3333;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_in_ready", 32'(in_ready), 32'd1);
      check("fl_count", 32'(decode_cnt), 32'(cnt0));
      @(posedge clk); #1;
      check("fl_discard", 32'(out_valid), 32'd0);

      // Random traffic with occasional flushes and one mid-stream reset
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         instr_in  = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         if (i == 700) begin
            #2 rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
      end
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Counter wrap: run up to all-ones, then one more transfer
      n = int'(16'hFFFF - exp_cnt);
      for (int i = 0; i < n; i++) send($urandom);
      @(posedge clk); #1;
      check("wrap_max", 32'(decode_cnt), 32'hFFFF);
      send(32'hCAFE_F00D);
      @(posedge clk); #1;
      check("wrap_zero", 32'(decode_cnt), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
